// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO Gray-pointer pair: local pointers, peer synchroniser, full/empty flag.
// Define GRAY_PTR_LEVEL_EN to build the occupancy level and almost flag.
module gray_ptr_ctrl #(
    parameter int AW          = 4,
    parameter int SIDE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic [AW:0]   remote_gray,
    output logic [AW:0]   ptr_bin,
    output logic [AW:0]   ptr_gray,
    output logic [AW-1:0] addr,
    output logic          accept,
    output logic          blocked,
    output logic [AW:0]   level,
    output logic          almost
);
    localparam int            PW          = AW + 1;
    // Full pattern: peer pointer with its two MSBs inverted (works for AW=1 too).
    localparam logic [PW-1:0] FULL_MASK   = ~({PW{1'b1}} >> 2);
    localparam logic          RST_BLOCKED = (SIDE != 0);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_blocked;

    logic [PW-1:0] w_rsync;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic          w_accept;
    logic          w_blocked_next;

    assign w_rsync     = r_sync[SYNC_STAGES-1];
    assign w_accept    = inc & ~r_blocked;
    assign w_bin_next  = r_bin + {{AW{1'b0}}, w_accept};
    assign w_gray_next = bin2gray(w_bin_next);

    // Flag is evaluated on the next pointer so it is ready the same edge the pointer moves.
    always_comb begin
        w_blocked_next = 1'b0;
        if (SIDE != 0) begin
            w_blocked_next = (w_gray_next == w_rsync);
        end else begin
            w_blocked_next = (w_gray_next == (w_rsync ^ FULL_MASK));
        end
    end

    // Peer Gray pointer synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {PW{1'b0}};
            end
        end else begin
            r_sync[0] <= remote_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Local pointers and the blocked flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= {PW{1'b0}};
            r_gray    <= {PW{1'b0}};
            r_blocked <= RST_BLOCKED;
        end else begin
            r_bin     <= w_bin_next;
            r_gray    <= w_gray_next;
            r_blocked <= w_blocked_next;
        end
    end

    assign ptr_bin  = r_bin;
    assign ptr_gray = r_gray;
    assign addr     = r_bin[AW-1:0];
    assign accept   = w_accept;
    assign blocked  = r_blocked;

`ifdef GRAY_PTR_LEVEL_EN
    localparam int ALMOST_HI = (1 << AW) - ALMOST_TH;

    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic          w_almost_next;
    logic [PW-1:0] r_level;
    logic          r_almost;

    assign w_rbin = gray2bin(w_rsync);

    // Modulo-2^PW difference keeps the level correct across pointer wrap.
    always_comb begin
        w_level_next  = {PW{1'b0}};
        w_almost_next = 1'b0;
        if (SIDE != 0) begin
            w_level_next  = w_rbin - w_bin_next;
            w_almost_next = (32'(w_level_next) <= ALMOST_TH);
        end else begin
            w_level_next  = w_bin_next - w_rbin;
            w_almost_next = (32'(w_level_next) >= ALMOST_HI);
        end
    end

    // Registered occupancy and almost flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level  <= {PW{1'b0}};
            r_almost <= RST_BLOCKED;
        end else begin
            r_level  <= w_level_next;
            r_almost <= w_almost_next;
        end
    end

    assign level  = r_level;
    assign almost = r_almost;
`else
    assign level  = {PW{1'b0}};
    assign almost = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: a write-side and a read-side instance, AW=2, SYNC_STAGES=2.
module tb_gray_ptr_ctrl;
    localparam int AW = 2;

`ifdef GRAY_PTR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_inc, r_inc;
    logic [2:0] w_remote, r_remote;
    logic [2:0] w_ptr_bin, w_ptr_gray, w_level;
    logic [2:0] r_ptr_bin, r_ptr_gray, r_level;
    logic [1:0] w_addr, r_addr;
    logic       w_accept, w_blocked, w_almost;
    logic       r_accept, r_blocked, r_almost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_ptr_ctrl #(.AW(AW), .SIDE(0), .SYNC_STAGES(2), .ALMOST_TH(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .inc(w_inc), .remote_gray(w_remote),
        .ptr_bin(w_ptr_bin), .ptr_gray(w_ptr_gray), .addr(w_addr), .accept(w_accept),
        .blocked(w_blocked), .level(w_level), .almost(w_almost)
    );

    gray_ptr_ctrl #(.AW(AW), .SIDE(1), .SYNC_STAGES(2), .ALMOST_TH(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .inc(r_inc), .remote_gray(r_remote),
        .ptr_bin(r_ptr_bin), .ptr_gray(r_ptr_gray), .addr(r_addr), .accept(r_accept),
        .blocked(r_blocked), .level(r_level), .almost(r_almost)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] g2b(input logic [2:0] gr);
        logic [2:0] b;
        b[2] = gr[2];
        b[1] = b[2] ^ gr[1];
        b[0] = b[1] ^ gr[0];
        return b;
    endfunction

    initial begin
        logic [2:0] mb, bn, gn, rb, ms0, ms1, mlvl, prev_gray, prev_bin;
        logic       mblk, acc, wrap_seen;
        logic [2:0] hist [20];
        int         e;

        w_inc = 1'b0; r_inc = 1'b0; w_remote = 3'd0; r_remote = 3'd0;
        repeat (2) tick();
        rst_n = 1'b1;

        check_eq("rst_w_bin",     32'(w_ptr_bin), 32'd0);
        check_eq("rst_w_gray",    32'(w_ptr_gray), 32'd0);
        check_eq("rst_w_blocked", 32'(w_blocked), 32'd0);
        check_eq("rst_w_almost",  32'(w_almost), 32'd0);
        check_eq("rst_w_level",   32'(w_level), 32'd0);
        check_eq("rst_r_bin",     32'(r_ptr_bin), 32'd0);
        check_eq("rst_r_gray",    32'(r_ptr_gray), 32'd0);
        check_eq("rst_r_blocked", 32'(r_blocked), 32'd1);
        check_eq("rst_r_almost",  32'(r_almost), 32'(LVL_EN));

        // Fill the write side against a stalled peer.
        w_inc = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [2:0] ex;
            ex = (k < 4) ? 3'(k) : 3'd4;
            #1;
            check_eq("fill_accept", 32'(w_accept), 32'(k <= 4));
            tick();
            check_eq("fill_bin",     32'(w_ptr_bin), 32'(ex));
            check_eq("fill_gray",    32'(w_ptr_gray), 32'(g(ex)));
            check_eq("fill_addr",    32'(w_addr), 32'(ex[1:0]));
            check_eq("fill_blocked", 32'(w_blocked), 32'(k >= 4));
            check_eq("fill_level",   32'(w_level), LVL_EN ? 32'(ex) : 32'd0);
            check_eq("fill_almost",  32'(w_almost), 32'(LVL_EN && (ex >= 3'd3)));
        end
        w_inc = 1'b0;

        // Peer pops one entry: visible exactly three edges later.
        w_remote = 3'b001;
        for (e = 1; e <= 3; e++) begin
            tick();
            check_eq("drain_blocked", 32'(w_blocked), 32'(e < 3));
            check_eq("drain_level",   32'(w_level), LVL_EN ? ((e < 3) ? 32'd4 : 32'd3) : 32'd0);
        end

        // Read side sees two written entries, then pops them.
        r_remote = 3'b011;
        for (e = 1; e <= 3; e++) begin
            tick();
            check_eq("rd_vis_blocked", 32'(r_blocked), 32'(e < 3));
            check_eq("rd_vis_level",   32'(r_level), LVL_EN ? ((e == 3) ? 32'd2 : 32'd0) : 32'd0);
            check_eq("rd_vis_almost",  32'(r_almost), 32'(LVL_EN && (e < 3)));
        end
        r_inc = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            logic [2:0] ex;
            ex = (p < 2) ? 3'(p) : 3'd2;
            #1;
            check_eq("pop_accept", 32'(r_accept), 32'(p <= 2));
            tick();
            check_eq("pop_bin",     32'(r_ptr_bin), 32'(ex));
            check_eq("pop_blocked", 32'(r_blocked), 32'(p >= 2));
            check_eq("pop_level",   32'(r_level), LVL_EN ? 32'(3'd2 - ex) : 32'd0);
            check_eq("pop_almost",  32'(r_almost), 32'(LVL_EN));
        end
        r_inc = 1'b0;

        // Async reset in the middle of a fill.
        w_remote = 3'd0; r_remote = 3'd0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        w_inc = 1'b1;
        repeat (3) tick();
        w_inc = 1'b0;
        check_eq("pre_rst_bin",   32'(w_ptr_bin), 32'd3);
        check_eq("pre_rst_level", 32'(w_level), LVL_EN ? 32'd3 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_clk_high", 32'(clk), 32'd1);
        check_eq("arst_bin",      32'(w_ptr_bin), 32'd0);
        check_eq("arst_gray",     32'(w_ptr_gray), 32'd0);
        check_eq("arst_blocked",  32'(w_blocked), 32'd0);
        check_eq("arst_level",    32'(w_level), 32'd0);
        check_eq("arst_almost",   32'(w_almost), 32'd0);
        check_eq("arst_r_blocked", 32'(r_blocked), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        w_inc = 1'b1;
        tick();
        check_eq("post_rst_bin", 32'(w_ptr_bin), 32'd1);
        w_inc = 1'b0;

        // Wrap: continuous push with a model peer trailing three cycles behind.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mb = 3'd0; mblk = 1'b0; ms0 = 3'd0; ms1 = 3'd0;
        prev_gray = 3'd0; prev_bin = 3'd0; wrap_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            w_inc    = 1'b1;
            w_remote = (k >= 3) ? g(hist[k-3]) : 3'd0;
            acc  = ~mblk;
            bn   = mb + {2'b00, acc};
            gn   = g(bn);
            rb   = g2b(ms1);
            mblk = (gn == (ms1 ^ 3'b110));
            mlvl = bn - rb;
            ms1  = ms0;
            ms0  = w_remote;
            mb   = bn;
            #1;
            check_eq("wrap_accept", 32'(w_accept), 32'(acc));
            tick();
            check_eq("wrap_bin",     32'(w_ptr_bin), 32'(mb));
            check_eq("wrap_gray",    32'(w_ptr_gray), 32'(gn));
            check_eq("wrap_onebit",  32'($countones(w_ptr_gray ^ prev_gray)), 32'(acc));
            check_eq("wrap_blocked", 32'(w_blocked), 32'(mblk));
            check_eq("wrap_level",   32'(w_level), LVL_EN ? 32'(mlvl) : 32'd0);
            check_eq("wrap_almost",  32'(w_almost), 32'(LVL_EN && (mlvl >= 3'd3)));
            if (prev_bin == 3'd7 && w_ptr_bin == 3'd0) begin
                wrap_seen = 1'b1;
            end else begin
                wrap_seen = wrap_seen;
            end
            hist[k]   = mb;
            prev_gray = w_ptr_gray;
            prev_bin  = w_ptr_bin;
        end
        w_inc = 1'b0;
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
